// File: rtl/fir_mac_scheduler_if.sv
// Sample-in / filtered-out handshake bundle for the shared-MAC FIR.
// Master drives samples, slave returns results and status.
interface fir_mac_scheduler_if #(
  parameter int DW = 10
);
  logic [DW-1:0] sample_in;
  logic          sample_valid;
  logic          busy;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          overrun;

  modport master (
    output sample_in,
    output sample_valid,
    input  busy,
    input  out_data,
    input  out_valid,
    input  overrun
  );

  modport slave (
    input  sample_in,
    input  sample_valid,
    output busy,
    output out_data,
    output out_valid,
    output overrun
  );
endinterface

// File: rtl/fir_mac_scheduler.sv
// 31-tap symmetric FIR, one shared MAC over 16 tap pairs per sample.
// Define FIR_ROUND_EN for round-half-up scaling instead of truncation.
module fir_mac_scheduler #(
  parameter int DW    = 10,
  parameter int NTAPS = 31,
  parameter int SHIFT = 10
) (
  input  logic clk,
  input  logic reset,
  fir_mac_scheduler_if.slave bus
);

  localparam int PW = DW + 1;
  localparam int CW = 7;
  localparam int MW = PW + CW;
  localparam int AW = 21;
  localparam logic [4:0]    LAST = 5'(NTAPS - 1);
  localparam logic [AW-1:0] MAXV = AW'((1 << DW) - 1);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    SCALE
  } state_t;

  state_t        state;
  logic [4:0]    wp;
  logic [4:0]    newest;
  logic [3:0]    k;
  logic [AW-1:0] acc;
  logic [DW-1:0] hist [NTAPS];
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          overrun;

  function automatic logic [CW-1:0] coef(input logic [3:0] i);
    logic [CW-1:0] c;
    unique case (i)
      4'd0:    c = 7'd3;
      4'd1:    c = 7'd4;
      4'd2:    c = 7'd6;
      4'd3:    c = 7'd8;
      4'd4:    c = 7'd12;
      4'd5:    c = 7'd17;
      4'd6:    c = 7'd23;
      4'd7:    c = 7'd29;
      4'd8:    c = 7'd36;
      4'd9:    c = 7'd43;
      4'd10:   c = 7'd50;
      4'd11:   c = 7'd56;
      4'd12:   c = 7'd61;
      4'd13:   c = 7'd65;
      4'd14:   c = 7'd67;
      default: c = 7'd68;
    endcase
    return c;
  endfunction

  logic [5:0]    diff_a;
  logic [5:0]    sum_b;
  logic [4:0]    idx_a;
  logic [4:0]    idx_b;
  logic [PW-1:0] pair;
  logic [MW-1:0] prod;
  logic [AW-1:0] acc_r;
  logic [AW-1:0] scaled;
  logic [DW-1:0] sat;

  // Both indices are wrapped mod 31 with 5-bit adds; 32-wrap folds in
  always_comb begin
    diff_a = {1'b0, newest} - {2'b0, k};
    sum_b  = {1'b0, newest} + {2'b0, k} + 6'd1;
    idx_a  = diff_a[5] ? diff_a[4:0] + 5'd31
                       : diff_a[4:0];
    idx_b  = (sum_b >= 6'd31) ? sum_b[4:0] - 5'd31
                              : sum_b[4:0];
    // Centre tap has no partner; both indices coincide there
    if (k == 4'd15) begin
      pair = {1'b0, hist[idx_a]};
    end else begin
      pair = {1'b0, hist[idx_a]} + {1'b0, hist[idx_b]};
    end
    prod = {{PW{1'b0}}, coef(k)} * {{CW{1'b0}}, pair};
  end

  always_comb begin
`ifdef FIR_ROUND_EN
    acc_r = acc + (AW'(1) << (SHIFT - 1));
`else
    acc_r = acc;
`endif
    scaled = acc_r >> SHIFT;
    sat    = (scaled > MAXV) ? '1 : scaled[DW-1:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      wp        <= '0;
      newest    <= '0;
      k         <= '0;
      acc       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
      for (int i = 0; i < NTAPS; i++) begin
        hist[i] <= '0;
      end
    end else begin
      out_valid <= 1'b0;
      overrun   <= bus.sample_valid && (state != IDLE);
      unique case (state)
        IDLE: begin
          if (bus.sample_valid) begin
            hist[wp] <= bus.sample_in;
            newest   <= wp;
            wp       <= (wp == LAST) ? 5'd0 : wp + 5'd1;
            acc      <= '0;
            k        <= '0;
            state    <= ACCUM;
          end
        end
        ACCUM: begin
          acc <= acc + {{(AW-MW){1'b0}}, prod};
          k   <= k + 4'd1;
          if (k == 4'd15) begin
            state <= SCALE;
          end
        end
        SCALE: begin
          out_data  <= sat;
          out_valid <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy      = (state != IDLE);
  assign bus.out_data  = out_data;
  assign bus.out_valid = out_valid;
  assign bus.overrun   = overrun;

endmodule

// File: doc/fir_mac_scheduler.md
# fir_mac_scheduler

Time-multiplexed FIR controller for the heart-rate signal chain: accepts one 10-bit sample per strobe from the SPI front end, stores it in a 31-entry circular history, and sequences a single shared multiply-accumulate over the 16 symmetric tap pairs of the 31-tap low-pass filter. It replaces the fully parallel filter datapath, sits between the SPI sample capture and the peak detector, and emits one registered, saturated 10-bit output per accepted sample with a valid strobe.

## Interface

Parameters:
- `DW`, 10, sample and output width
- `NTAPS`, 31, filter length; odd, fixed symmetric
- `SHIFT`, 10, right shift applied to the accumulator (coefficients are scaled by 2^10)

Ports:
- `clk`  in  1  system clock, all logic on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `sample_in`  in  DW  new sample, qualified by `sample_valid`
- `sample_valid`  in  1  one-cycle strobe; sample captured at this edge
- `busy`  out  1  high while a filter pass is in progress
- `out_data`  out  DW  filtered sample, held until next result
- `out_valid`  out  1  one-cycle strobe, `out_data` new
- `overrun`  out  1  one-cycle pulse, `sample_valid` arrived while busy

## Operation

- Coefficient ROM c[0..15] = 3,4,6,8,12,17,23,29,36,43,50,56,61,65,67,68; c[15] is the centre tap.
- History buffer x[0..30], write pointer `wp` (5 bits, 0..30, wraps 30→0).
- FSM states: IDLE, ACCUM, SCALE.
  - IDLE: on `sample_valid`, write `sample_in` to x[wp], hold that index as `newest`, advance `wp`, clear accumulator, k←0 → ACCUM.
  - ACCUM: one MAC per cycle. For k=0..14: acc += c[k]·(x[(newest−k) mod 31] + x[(newest+1+k) mod 31]). For k=15: acc += c[15]·x[(newest−15) mod 31]. After k=15 → SCALE.
  - SCALE: result = acc >> SHIFT; if result > 2^DW−1 then out_data = 2^DW−1; assert `out_valid` → IDLE.
- Widths: pair sum 11 bits unsigned; product 18 bits; accumulator 21 bits (max 1028·1023 = 1,051,644); no overflow possible.
- `sample_valid` in ACCUM or SCALE: sample discarded, buffer and `wp` untouched, `overrun` pulses next cycle, current pass unaffected.
- `busy` = (state ≠ IDLE).
- Reset values: state IDLE, `wp`=0, all x[]=0, acc=0, `out_data`=0, `out_valid`=0, `overrun`=0, `busy`=0. Reset mid-pass aborts; no `out_valid` issued for the aborted sample.

## Timing

- E0 = edge where `sample_valid` is sampled high in IDLE.
- E1..E16: 16 MAC edges (k=0..15).
- E17: SCALE edge; `out_data` and `out_valid`=1 registered; state → IDLE.
- `out_valid` high exactly one cycle (E17 to E18); latency E0→valid = 17 cycles.
- `busy` high from after E0 through after E17 (17 cycles).
- Next sample accepted earliest at E18; minimum sample spacing 18 cycles.
- `overrun` registered: high for the cycle after the offending edge.

## Configuration

- `FIR_ROUND_EN` defined: SCALE computes (acc + 2^(SHIFT−1)) >> SHIFT (round half up), then saturates.
- Not defined: truncating shift, then saturates. All other behaviour identical.

## Test plan

- Reset: hold `reset`=0 with `sample_valid` toggling → all outputs 0, no `out_valid`; after release, no spontaneous `out_valid`.
- Single sample 512 after reset → `out_valid` 17 cycles later, `out_data`=1 (truncate) / 2 (`FIR_ROUND_EN`).
- DC 1023, 31 samples at 18-cycle spacing → 31st output 1023 (acc 1,051,644 >>10 = 1027, saturated).
- Wrap: 40 samples of 100 → outputs 31..40 all 100 in both configs; `wp` wraps 30→0 without glitch.
- Overrun: second `sample_valid` at E5 → `overrun` high one cycle at E6, result at E17 matches single-sample case, next accepted sample uses `wp`=1.
- Reset asserted at E8 → `busy`=0 immediately, no `out_valid`; subsequent sample 512 reproduces the single-sample result.
